keypad_load_encoder: RTL and testbench

Keypad-side writer for the microwave timer's parallel-load interface. It synchronizes and debounces the 10-key one-hot keypad, encodes each accepted key to BCD on `D`, and issues a one-cycle active-low `loadn` strobe per digit. The countdown timer shifts each digit in. The block also generates the free-running one-cycle `pgt_1Hz` tick that clocks the countdown. Key entry is inhibited while the magnetron is on.

---
 rtl/keypad_load_encoder_if.sv | 22 ++
 rtl/keypad_load_encoder.sv | 146 ++++++++++++++
 tb/tb_keypad_load_encoder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_load_encoder_if.sv
// Parallel-load bus between the keypad encoder (master) and the countdown timer (slave).
// Carries the BCD digit, its load strobe, the 1 Hz tick and the entry digit count.
interface keypad_load_encoder_if;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic [1:0] digits;

  modport master (
    output D,
    output loadn,
    output pgt_1Hz,
    output digits
  );

  modport slave (
    input D,
    input loadn,
    input pgt_1Hz,
    input digits
  );
endinterface

// File: rtl/keypad_load_encoder.sv
// Keypad writer for the microwave timer: synchronizes and debounces a one-hot keypad,
// strobes each accepted BCD digit onto the load bus, and generates the 1 Hz tick.
module keypad_load_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000,
  parameter int MAX_DIGITS      = 3
) (
  input  logic                         clock,
  input  logic                         clearn,
  input  logic [9:0]                   keypad,
  input  logic                         enablen,
  keypad_load_encoder_if.master        load_bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TICK_LAST  = TK_W'(TICK_DIV - 1);
  localparam logic [1:0]      DIGITS_MAX = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOAD,
    RELEASE
  } state_t;

  function automatic logic is_onehot(input logic [9:0] k);
    return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [3:0] onehot_code(input logic [9:0] k);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) code = 4'(i);
    end
    return code;
  endfunction

  logic [9:0]      key_p0;
  logic [9:0]      key_p1;
  logic            ks_valid;
  logic [3:0]      ks_code;

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic [9:0]      cap_key;
  logic [3:0]      cap_code;
  logic [3:0]      d_r;
  logic            loadn_r;
  logic [1:0]      digits_r;

  logic [TK_W-1:0] tick_cnt;
  logic            tick_r;

  // Stage p0/p1: two-flop synchronizer for the asynchronous keypad
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      key_p0 <= 10'd0;
      key_p1 <= 10'd0;
    end else begin
      key_p0 <= keypad;
      key_p1 <= key_p0;
    end
  end

  assign ks_valid = is_onehot(key_p1);
  assign ks_code  = onehot_code(key_p1);

  // Stage FSM: acquire, debounce, strobe, then wait for a clean release
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state    <= IDLE;
      db_cnt   <= '0;
      cap_key  <= 10'd0;
      cap_code <= 4'd0;
      d_r      <= 4'd0;
      loadn_r  <= 1'b1;
      digits_r <= 2'd0;
    end else begin
      loadn_r <= 1'b1;
      case (state)
        IDLE: begin
          if (!enablen && ks_valid) begin
            db_cnt <= '0;
            if (digits_r < DIGITS_MAX) begin
              cap_key  <= key_p1;
              cap_code <= ks_code;
              state    <= DEBOUNCE;
            end else begin
              state <= RELEASE;
            end
          end
        end
        DEBOUNCE: begin
          if ((key_p1 != cap_key) || enablen) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            // Outputs are registered here so the strobe coincides with the LOAD state
            state    <= LOAD;
            loadn_r  <= 1'b0;
            d_r      <= cap_code;
            digits_r <= digits_r + 2'd1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        LOAD: begin
          state  <= RELEASE;
          db_cnt <= '0;
        end
        RELEASE: begin
          if (key_p1 != 10'd0) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // Magnetron on starts a fresh entry regardless of FSM state
      if (enablen) digits_r <= 2'd0;
    end
  end

  // Stage tick: free-running prescaler, pulse registered one cycle after the last count
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      tick_cnt <= '0;
      tick_r   <= 1'b0;
    end else begin
      tick_r <= (tick_cnt == TICK_LAST);
      if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign load_bus.D       = d_r;
  assign load_bus.loadn   = loadn_r;
  assign load_bus.digits  = digits_r;
  assign load_bus.pgt_1Hz = tick_r;

endmodule

// File: tb/tb_keypad_load_encoder.sv
// Directed bench for keypad_load_encoder with DEBOUNCE_CYCLES=4, TICK_DIV=10.
module tb_keypad_load_encoder;
  logic       clk;
  logic       clearn;
  logic [9:0] keypad;
  logic       enablen;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int strobe_cnt = 0;
  int last_strobe_cyc = -1;
  logic [3:0] last_d = 4'd0;

  keypad_load_encoder_if bus ();

  keypad_load_encoder #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV(10),
    .MAX_DIGITS(3)
  ) dut (
    .clock(clk),
    .clearn(clearn),
    .keypad(keypad),
    .enablen(enablen),
    .load_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.loadn === 1'b0) begin
      strobe_cnt      <= strobe_cnt + 1;
      last_strobe_cyc <= cyc;
      last_d          <= bus.D;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    keypad  = 10'd0;
    enablen = 1'b0;
    @(negedge clk);
    clearn = 1'b0;
    @(negedge clk);
    clearn = 1'b1;
    repeat (3) tick();
  endtask

  // Press a key for hold cycles, release, then idle long enough for RELEASE to finish
  task automatic press(input logic [9:0] k, input int hold);
    keypad = k;
    repeat (hold) tick();
    keypad = 10'd0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    keypad  = 10'd0;
    enablen = 1'b0;
    clearn  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (bus.D !== 4'd0) begin n_fail++; $display("FAIL reset_D got %0d want 0", bus.D); end
    n_checks++;
    if (bus.loadn !== 1'b1) begin n_fail++; $display("FAIL reset_loadn got %b want 1", bus.loadn); end
    n_checks++;
    if (bus.digits !== 2'd0) begin n_fail++; $display("FAIL reset_digits got %0d want 0", bus.digits); end
    n_checks++;
    if (bus.pgt_1Hz !== 1'b0) begin n_fail++; $display("FAIL reset_pgt got %b want 0", bus.pgt_1Hz); end
    @(negedge clk);
    clearn = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      logic exp;
      tick();
      exp = (k % 10 == 0);
      n_checks++;
      if (bus.pgt_1Hz !== exp) begin
        n_fail++;
        $display("FAIL pgt_edge%0d got %b want %b", k, bus.pgt_1Hz, exp);
      end
    end
  endtask

  task automatic test_single_key();
    int t, s0;
    do_reset();
    s0 = strobe_cnt;
    keypad = 10'b0000100000;
    t = cyc + 1;
    repeat (30) tick();
    keypad = 10'd0;
    repeat (12) tick();
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", strobe_cnt - s0); end
    n_checks++;
    if (last_strobe_cyc !== t + 6) begin n_fail++; $display("FAIL single_latency got %0d want %0d", last_strobe_cyc, t + 6); end
    n_checks++;
    if (last_d !== 4'd5) begin n_fail++; $display("FAIL single_D got %0d want 5", last_d); end
    n_checks++;
    if (bus.D !== 4'd5) begin n_fail++; $display("FAIL single_D_hold got %0d want 5", bus.D); end
    n_checks++;
    if (bus.digits !== 2'd1) begin n_fail++; $display("FAIL single_digits got %0d want 1", bus.digits); end
  endtask

  task automatic test_entry_sequence();
    int keys [3] = '{1, 3, 0};
    int s0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s0 = strobe_cnt;
      press(10'd1 << keys[i], 10);
      n_checks++;
      if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL entry%0d_count got %0d want 1", i, strobe_cnt - s0); end
      n_checks++;
      if (last_d !== 4'(keys[i])) begin n_fail++; $display("FAIL entry%0d_D got %0d want %0d", i, last_d, keys[i]); end
    end
    n_checks++;
    if (bus.digits !== 2'd3) begin n_fail++; $display("FAIL entry_digits got %0d want 3", bus.digits); end
    s0 = strobe_cnt;
    press(10'b0010000000, 10);
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL sat_count got %0d want 0", strobe_cnt - s0); end
    n_checks++;
    if (bus.D !== 4'd0) begin n_fail++; $display("FAIL sat_D got %0d want 0", bus.D); end
    n_checks++;
    if (bus.digits !== 2'd3) begin n_fail++; $display("FAIL sat_digits got %0d want 3", bus.digits); end
  endtask

  task automatic test_bounce_multikey();
    int t, s0;
    do_reset();
    s0 = strobe_cnt;
    keypad = 10'b0000000100;
    repeat (2) tick();
    keypad = 10'd0;
    tick();
    keypad = 10'b0000000100;
    t = cyc + 1;
    repeat (10) tick();
    keypad = 10'd0;
    repeat (12) tick();
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL bounce_count got %0d want 1", strobe_cnt - s0); end
    n_checks++;
    if (last_strobe_cyc !== t + 6) begin n_fail++; $display("FAIL bounce_latency got %0d want %0d", last_strobe_cyc, t + 6); end
    n_checks++;
    if (last_d !== 4'd2) begin n_fail++; $display("FAIL bounce_D got %0d want 2", last_d); end
    s0 = strobe_cnt;
    press(10'b0000011000, 10);
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL multikey_count got %0d want 0", strobe_cnt - s0); end
    n_checks++;
    if (bus.digits !== 2'd1) begin n_fail++; $display("FAIL multikey_digits got %0d want 1", bus.digits); end
  endtask

  task automatic test_inhibit();
    int e, s0;
    do_reset();
    s0 = strobe_cnt;
    enablen = 1'b1;
    keypad  = 10'b1000000000;
    repeat (10) tick();
    n_checks++;
    if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL inhibit_count got %0d want 0", strobe_cnt - s0); end
    n_checks++;
    if (bus.digits !== 2'd0) begin n_fail++; $display("FAIL inhibit_digits got %0d want 0", bus.digits); end
    enablen = 1'b0;
    e = cyc + 1;
    repeat (10) tick();
    keypad = 10'd0;
    repeat (12) tick();
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL uninhibit_count got %0d want 1", strobe_cnt - s0); end
    n_checks++;
    if (last_strobe_cyc < e || last_strobe_cyc > e + 6) begin
      n_fail++;
      $display("FAIL uninhibit_latency got %0d want %0d..%0d", last_strobe_cyc, e, e + 6);
    end
    n_checks++;
    if (last_d !== 4'd9) begin n_fail++; $display("FAIL uninhibit_D got %0d want 9", last_d); end
    n_checks++;
    if (bus.digits !== 2'd1) begin n_fail++; $display("FAIL uninhibit_digits got %0d want 1", bus.digits); end
    enablen = 1'b1;
    tick();
    enablen = 1'b0;
    n_checks++;
    if (bus.digits !== 2'd0) begin n_fail++; $display("FAIL enablen_clear got %0d want 0", bus.digits); end
  endtask

  task automatic test_clear_mid_entry();
    int s0;
    bit seen;
    do_reset();
    press(10'b0000010000, 10);
    press(10'b0001000000, 10);
    n_checks++;
    if (bus.digits !== 2'd2) begin n_fail++; $display("FAIL pre_clear_digits got %0d want 2", bus.digits); end
    n_checks++;
    if (bus.D !== 4'd6) begin n_fail++; $display("FAIL pre_clear_D got %0d want 6", bus.D); end
    @(negedge clk);
    clearn = 1'b0;
    #1;
    n_checks++;
    if (bus.digits !== 2'd0) begin n_fail++; $display("FAIL clear_digits got %0d want 0", bus.digits); end
    n_checks++;
    if (bus.D !== 4'd0) begin n_fail++; $display("FAIL clear_D got %0d want 0", bus.D); end
    @(negedge clk);
    clearn = 1'b1;
    tick();
    s0 = strobe_cnt;
    press(10'b0100000000, 10);
    n_checks++;
    if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL after_clear_count got %0d want 1", strobe_cnt - s0); end
    n_checks++;
    if (bus.D !== 4'd8) begin n_fail++; $display("FAIL after_clear_D got %0d want 8", bus.D); end
    n_checks++;
    if (bus.digits !== 2'd1) begin n_fail++; $display("FAIL after_clear_digits got %0d want 1", bus.digits); end
    // Reset while the strobe is active must raise loadn without a clock edge
    keypad = 10'b0000001000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.loadn === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midload_wait got no strobe want strobe within 20 cycles");
    end else begin
      #1;
      clearn = 1'b0;
      keypad = 10'd0;
      #1;
      n_checks++;
      if (bus.loadn !== 1'b1) begin n_fail++; $display("FAIL midload_loadn got %b want 1", bus.loadn); end
    end
    @(negedge clk);
    clearn = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_entry_sequence();
    test_bounce_multikey();
    test_inhibit();
    test_clear_mid_entry();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
